// File: rtl/alu_seq.sv
// Registered ALU with accumulator, carry-chained add/sub and flags.
// Define ALU_SEQ_SHIFT_EN to build the iterative shifter (modes 1010-1100).
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       mode,
  input  logic             use_acc,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] ob;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   ext;
  logic [3:0]       nf;
  logic             c;
  logic             v;
  logic             sub;
  logic             ci;
  logic             arith;

  assign a = use_acc ? acc : A;

  always_comb begin
    ob    = B;
    ci    = 1'b0;
    sub   = 1'b0;
    arith = 1'b1;
    case (mode)
      4'b0000: arith = 1'b1;
      4'b0001: sub   = 1'b1;
      4'b0010: ob    = WIDTH'(1);
      4'b0011: begin
        ob  = WIDTH'(1);
        sub = 1'b1;
      end
      4'b1000: ci = flags[3];
      4'b1001: begin
        ci  = flags[3];
        sub = 1'b1;
      end
      default: arith = 1'b0;
    endcase
  end

  // One shared adder; bit WIDTH is carry for add and borrow for sub.
  assign ext = sub
    ? {1'b0, a} - {1'b0, ob} - {{WIDTH{1'b0}}, ci}
    : {1'b0, a} + {1'b0, ob} + {{WIDTH{1'b0}}, ci};

  always_comb begin
    res = a;
    c   = 1'b0;
    v   = 1'b0;
    if (arith) begin
      res = ext[MSB:0];
      c   = ext[WIDTH];
      if (sub)
        v = (a[MSB] ^ ob[MSB]) & (res[MSB] ^ a[MSB]);
      else
        v = ~(a[MSB] ^ ob[MSB]) & (res[MSB] ^ a[MSB]);
    end else begin
      case (mode)
        4'b0100: res = a & B;
        4'b0101: res = a | B;
        4'b0110: res = a ^ B;
        4'b0111: res = ~a;
        4'b1101: res = B;
        default: res = a;
      endcase
    end
  end

  assign nf = {c, v, res[MSB], res == '0};

`ifdef ALU_SEQ_SHIFT_EN
  localparam int SW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [SW-1:0]    cnt;
  logic [SW-1:0]    amt;
  logic [1:0]       kind;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] wnext;
  logic             cnext;
  logic             start;

  assign amt      = B[SW-1:0];
  assign start    = (mode == 4'b1010 || mode == 4'b1011 ||
                     mode == 4'b1100) && amt != '0;
  assign in_ready = !rst && state == IDLE;

  // kind is mode[1:0]: 10 SHL, 11 SHR, 00 SAR
  always_comb begin
    wnext = work;
    cnext = 1'b0;
    case (kind)
      2'b10: begin
        wnext = {work[MSB-1:0], 1'b0};
        cnext = work[MSB];
      end
      2'b11: begin
        wnext = {1'b0, work[MSB:1]};
        cnext = work[0];
      end
      default: begin
        wnext = {work[MSB], work[MSB:1]};
        cnext = work[0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      kind      <= '0;
      work      <= '0;
      out       <= '0;
      flags     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (start) begin
              work  <= a;
              cnt   <= amt;
              kind  <= mode[1:0];
              state <= SHIFT;
            end else begin
              out       <= res;
              flags     <= nf;
              acc       <= res;
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work <= wnext;
          cnt  <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            out       <= wnext;
            flags     <= {cnext, 1'b0, wnext[MSB], wnext == '0};
            acc       <= wnext;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign in_ready = !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      flags     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        out       <= res;
        flags     <= nf;
        acc       <= res;
        out_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8.
// Shift scenarios follow whichever ALU_SEQ_SHIFT_EN build is compiled.
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] mode;
  logic       use_acc;
  logic [7:0] out;
  logic       out_valid;
  logic [3:0] flags;

  int total;
  int bad;

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .mode     (mode),
    .use_acc  (use_acc),
    .out      (out),
    .out_valid(out_valid),
    .flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] m, input logic ua);
    @(negedge clk);
    A        = a;
    B        = b;
    mode     = m;
    use_acc  = ua;
    in_valid = 1'b1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got=%b want=0", in_ready);
    end
    total++;
    if (out !== 8'h00 || flags !== 4'h0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs got out=%h flags=%b ov=%b want 00/0000/0",
               out, flags, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_ops();
    logic [7:0] va [12] = '{8'hF0, 8'h80, 8'h7F, 8'h00, 8'hF0, 8'hF0,
                            8'hAA, 8'h0F, 8'h55, 8'h80, 8'h00, 8'h05};
    logic [7:0] vb [12] = '{8'h20, 8'h01, 8'h33, 8'h44, 8'h3C, 8'h0C,
                            8'hAA, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h05};
    logic [3:0] vm [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                            4'h6, 4'h7, 4'hD, 4'hE, 4'hF, 4'h1};
    logic [7:0] vr [12] = '{8'h10, 8'h7F, 8'h80, 8'hFF, 8'h30, 8'hFC,
                            8'h00, 8'hF0, 8'h00, 8'h80, 8'h00, 8'h00};
    logic [3:0] vf [12] = '{4'b1000, 4'b0100, 4'b0110, 4'b1010,
                            4'b0000, 4'b0010, 4'b0001, 4'b0010,
                            4'b0001, 4'b0010, 4'b0001, 4'b0001};
    for (int i = 0; i < 12; i++) begin
      drive(va[i], vb[i], vm[i], 1'b0);
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || out !== vr[i] || flags !== vf[i]) begin
        bad++;
        $display("FAIL op%0d got ov=%b out=%h flags=%b want 1/%h/%b",
                 i, out_valid, out, flags, vr[i], vf[i]);
      end
    end
    idle_cycle();
    total++;
    if (out_valid !== 1'b0 || out !== 8'h00) begin
      bad++;
      $display("FAIL ops_pulse got ov=%b out=%h want 0/00", out_valid, out);
    end
  endtask

  task automatic test_sub_sbb();
    drive(8'h80, 8'h01, 4'h1, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (out !== 8'h7F || flags !== 4'b0100 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL sub got out=%h flags=%b ov=%b want 7f/0100/1",
               out, flags, out_valid);
    end
    drive(8'hEE, 8'h7F, 4'h9, 1'b1);
    @(posedge clk);
    #1;
    total++;
    if (out !== 8'h00 || flags !== 4'b0001 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL sbb_acc got out=%h flags=%b ov=%b want 00/0001/1",
               out, flags, out_valid);
    end
  endtask

  task automatic test_carry_chain();
    drive(8'hF0, 8'h20, 4'h0, 1'b0);
    drive(8'hEE, 8'h01, 4'h8, 1'b1);
    @(posedge clk);
    #1;
    total++;
    if (out !== 8'h12 || flags !== 4'b0000) begin
      bad++;
      $display("FAIL adc_cin got out=%h flags=%b want 12/0000", out, flags);
    end
    drive(8'h00, 8'h01, 4'h1, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (out !== 8'hFF || flags !== 4'b1010) begin
      bad++;
      $display("FAIL sub_borrow got out=%h flags=%b want ff/1010", out, flags);
    end
    drive(8'h00, 8'h0F, 4'h9, 1'b1);
    @(posedge clk);
    #1;
    total++;
    if (out !== 8'hEF || flags !== 4'b0010) begin
      bad++;
      $display("FAIL sbb_bin got out=%h flags=%b want ef/0010", out, flags);
    end
  endtask

  task automatic test_back_to_back();
    drive(8'hAA, 8'h05, 4'hD, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (out !== 8'h05 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_pass got out=%h ov=%b rdy=%b want 05/1/1",
               out, out_valid, in_ready);
    end
    drive(8'hAA, 8'h03, 4'h0, 1'b1);
    @(posedge clk);
    #1;
    total++;
    if (out !== 8'h08 || out_valid !== 1'b1 || flags !== 4'b0000) begin
      bad++;
      $display("FAIL b2b_add got out=%h ov=%b flags=%b want 08/1/0000",
               out, out_valid, flags);
    end
    drive(8'hAA, 8'h00, 4'h7, 1'b1);
    @(posedge clk);
    #1;
    total++;
    if (out !== 8'hF7 || flags !== 4'b0010) begin
      bad++;
      $display("FAIL b2b_not_acc got out=%h flags=%b want f7/0010",
               out, flags);
    end
    idle_cycle();
  endtask

`ifdef ALU_SEQ_SHIFT_EN
  task automatic test_shift();
    drive(8'h81, 8'h03, 4'hA, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL shl_busy%0d got rdy=%b ov=%b want 0/0",
                 i, in_ready, out_valid);
      end
      idle_cycle();
    end
    total++;
    if (out_valid !== 1'b1 || out !== 8'h08 || flags !== 4'b0000 ||
        in_ready !== 1'b1) begin
      bad++;
      $display("FAIL shl_done got ov=%b out=%h flags=%b rdy=%b want 1/08/0000/1",
               out_valid, out, flags, in_ready);
    end
    drive(8'h90, 8'h02, 4'hC, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL sar_accept got ov=%b rdy=%b want 0/0", out_valid, in_ready);
    end
    idle_cycle();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL sar_busy got rdy=%b ov=%b want 0/0", in_ready, out_valid);
    end
    idle_cycle();
    total++;
    if (out_valid !== 1'b1 || out !== 8'hE4 || flags !== 4'b0010) begin
      bad++;
      $display("FAIL sar_done got ov=%b out=%h flags=%b want 1/e4/0010",
               out_valid, out, flags);
    end
    drive(8'h81, 8'h00, 4'hB, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || out !== 8'h81 || flags !== 4'b0010) begin
      bad++;
      $display("FAIL shr_zero got ov=%b out=%h flags=%b want 1/81/0010",
               out_valid, out, flags);
    end
    drive(8'h81, 8'h01, 4'hB, 1'b0);
    @(posedge clk);
    #1;
    idle_cycle();
    total++;
    if (out_valid !== 1'b1 || out !== 8'h40 || flags !== 4'b1000) begin
      bad++;
      $display("FAIL shr_one got ov=%b out=%h flags=%b want 1/40/1000",
               out_valid, out, flags);
    end
  endtask

  task automatic test_reset_in_shift();
    drive(8'h81, 8'h07, 4'hA, 1'b0);
    @(posedge clk);
    #1;
    repeat (3) idle_cycle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out !== 8'h00 || flags !== 4'h0 || out_valid !== 1'b0 ||
        in_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_regs got out=%h flags=%b ov=%b rdy=%b want 00/0000/0/0",
               out, flags, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_ready got=%b want=1", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL abort_quiet%0d got ov=%b rdy=%b want 0/1",
                 i, out_valid, in_ready);
      end
    end
    drive(8'hFF, 8'h00, 4'h0, 1'b1);
    @(posedge clk);
    #1;
    total++;
    if (out !== 8'h00 || flags !== 4'b0001 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL abort_acc got out=%h flags=%b ov=%b want 00/0001/1",
               out, flags, out_valid);
    end
    idle_cycle();
  endtask
`else
  task automatic test_no_shift();
    logic [7:0] va [3] = '{8'h81, 8'h81, 8'h90};
    logic [7:0] vb [3] = '{8'h03, 8'h03, 8'h02};
    logic [3:0] vm [3] = '{4'hB, 4'hA, 4'hC};
    logic [3:0] vf [3] = '{4'b0010, 4'b0010, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      drive(va[i], vb[i], vm[i], 1'b0);
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || out !== va[i] || flags !== vf[i] ||
          in_ready !== 1'b1) begin
        bad++;
        $display("FAIL noshift%0d got ov=%b out=%h flags=%b rdy=%b want 1/%h/%b/1",
                 i, out_valid, out, flags, in_ready, va[i], vf[i]);
      end
    end
    idle_cycle();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL noshift_idle got ov=%b rdy=%b want 0/1", out_valid, in_ready);
    end
  endtask
`endif

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    mode     = '0;
    use_acc  = 1'b0;
    test_reset();
    test_ops();
    test_sub_sbb();
    test_carry_chain();
    test_back_to_back();
`ifdef ALU_SEQ_SHIFT_EN
    test_shift();
    test_reset_in_shift();
`else
    test_no_shift();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised-width ALU and the next generation of the team's 8-bit combinational ALU. It keeps the same eight base operations (same encodings, widened to a 4-bit mode) and adds the following:
- a valid/ready operand handshake;
- a registered result with condition flags;
- an accumulator that can stand in for operand A;
- carry-chained add/subtract;
- multi-cycle iterative shifts.

It sits between the datapath register file and the writeback stage.

## Interface
- WIDTH, 8, datapath width; power of two, ≥4. SW = log2(WIDTH).
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode presented.
- in_ready  out  1  block can accept operands this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; B[SW-1:0] is the shift amount for shift modes.
- mode  in  4  operation select.
- use_acc  in  1  1: use the accumulator instead of A.
- out  out  WIDTH  registered result, held until the next result.
- out_valid  out  1  one-cycle pulse when a new result is written.
- flags  out  4  {C,V,N,Z}, registered with out.

## Operation
- Accept occurs when in_valid && in_ready. Operand a = use_acc ? acc : A, sampled at the accept edge.
- Modes:
  - 0000 a+B
  - 0001 a−B
  - 0010 a+1
  - 0011 a−1
  - 0100 a&B
  - 0101 a|B
  - 0110 a^B
  - 0111 ~a
  - 1000 a+B+C (ADC)
  - 1001 a−B−C (SBB; C acts as borrow)
  - 1010 SHL
  - 1011 SHR (logical)
  - 1100 SAR (arithmetic)
  - 1101 pass B
  - 1110/1111 reserved: result = a.
- Arithmetic is modulo 2^WIDTH.
- C flag:
  - add/inc/ADC: carry out of the MSB.
  - sub/dec/SBB: borrow, 1 when the unsigned minuend < subtrahend (+borrow-in).
  - shifts: last bit shifted out; 0 when the amount is 0.
  - logic/pass/reserved: 0.
- V flag: two's-complement overflow for add/sub/inc/dec/ADC/SBB; 0 otherwise.
- N = result[WIDTH-1]. Z = (result == 0).
- Every completed operation writes out, flags and acc together, and pulses out_valid.
- FSM states:
  - IDLE: in_ready=1. A single-cycle op, or a shift with amount 0, completes at the accept edge and the FSM stays in IDLE. A shift with amount k≥1 loads the work register, sets cnt=k, and moves to SHIFT.
  - SHIFT: in_ready=0. Each edge shifts the work register by 1 bit, captures the shifted-out bit into C_work, and decrements cnt. At the edge where cnt goes 1→0, it writes the result and returns to IDLE.
- in_valid during SHIFT is ignored. The source must hold it until in_ready is seen.
- Reset values:
  - out=0, flags=0, acc=0, out_valid=0, state=IDLE.
  - in_ready=0 while rst=1, and 1 in the first cycle after rst deasserts.
- Reset during SHIFT aborts the operation: no out_valid pulse, and acc and flags are cleared.

## Timing
- Single-cycle ops: out, flags and out_valid are visible in the cycle after the accept cycle (latency 1).
- Throughput for single-cycle ops is one op per cycle.
- Back-to-back ops with use_acc=1 see the acc written by the previous accept edge.
- ADC/SBB use the C flag as registered at the accept edge.
- Shift by k≥1: latency k+1 cycles. in_ready is low for k cycles after the accept cycle, and the next accept is possible in the same cycle out_valid is high.
- out_valid is never high for two consecutive cycles from the same operation.

## Configuration
- ALU_SEQ_SHIFT_EN defined:
  - modes 1010/1011/1100 are iterative shifts as above;
  - the SHIFT state and cnt exist.
- ALU_SEQ_SHIFT_EN undefined:
  - no SHIFT state; in_ready = !rst;
  - modes 1010–1100 behave as reserved (result = a, C=V=0, N/Z from the result), latency 1.

## Test plan
- WIDTH=8, ADD A=0xF0 B=0x20 → out=0x10, flags C=1 V=0 N=0 Z=0, out_valid a single pulse one cycle after accept.
- SUB A=0x80 B=0x01 → out=0x7F, C=0 V=1 N=0. Then SBB with use_acc=1, B=0x7F, C=0 → out=0x00, Z=1.
- Pass B=0x05, then ADD with use_acc=1 and B=0x03 issued on consecutive cycles → out=0x05, then 0x08. acc=0x08.
- SHL A=0x81 B=3 (macro defined) → in_ready low for 3 cycles, out=0x08, C=0, out_valid 4 cycles after accept. SAR A=0x90 B=2 → out=0xE4, N=1, C=0.
- Assert rst for 1 cycle mid-way through SHL by 7 → no out_valid pulse, out=0, flags=0, in_ready=1 in the cycle after rst drops.
- Macro undefined: SHR A=0x81 B=3 → out=0x81, C=0 V=0 N=1, latency 1, in_ready constantly 1.
